// File: rtl/spi_boot_sequencer_if.sv
// Memory write port between the boot sequencer and the instruction-memory interconnect.
interface spi_boot_sequencer_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;

    modport master (output req, output addr, output wdata, input gnt);
    modport slave  (input req, input addr, input wdata, output gnt);
endinterface

// File: rtl/spi_boot_sequencer.sv
// Boot sequencer: issues one continuous SPI READ (0x03) to the external flash and
// copies BOOT_WORDS little-endian 32-bit words into instruction memory, then
// raises the sticky boot_done flag.
module spi_boot_sequencer #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned BOOT_WORDS = 1024,
    parameter int unsigned SCK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        skip,
    output logic                        ss,
    output logic                        sck,
    output logic                        mosi,
    input  logic                        miso,
    spi_boot_sequencer_if.master        mem,
    output logic                        busy,
    output logic                        boot_done
);

    localparam int unsigned CNT_W = $clog2(BOOT_WORDS + 1);
    localparam int unsigned DIV_W = $clog2(SCK_DIV + 1);
    localparam logic [31:0]      CMD_WORD  = {8'h03, FLASH_BASE};
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(BOOT_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;
    logic              sck_q;
    logic              mosi_q;
    logic [31:0]       cmd_sr;
    logic [31:0]       rx_sr;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  word_cnt;

    logic              phase_end;
    logic              sck_rise;
    logic              sck_fall;
    logic              bit_last;
    logic              in_flash;

    // Chip select, busy and request are pure state decodes so an async reset clears them at once.
    assign in_flash  = (state == CMD) || (state == DATA) || (state == WRITE);
    assign ss        = !in_flash;
    assign busy      = in_flash;
    assign boot_done = (state == DONE);
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign mem.req   = (state == WRITE);
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and bit-timing strobes.
    always_comb begin
        state_next = state;
        phase_end  = 1'b0;
        if ((state == CMD) || (state == DATA)) begin
            phase_end = (div_cnt == DIV_LAST);
        end
        sck_rise = phase_end && !sck_q;
        sck_fall = phase_end && sck_q;
        bit_last = sck_fall && (bit_cnt == 5'd31);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = skip ? DONE : CMD;
                end
            end
            CMD: begin
                if (bit_last) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (mem.gnt) begin
                    state_next = (word_cnt == WORD_LAST) ? DONE : DATA;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // SPI shifting, sck generation, word assembly and write address/count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cmd_sr   <= '0;
            rx_sr    <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            word_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !skip) begin
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        sck_q    <= 1'b0;
                        mosi_q   <= CMD_WORD[31];
                        cmd_sr   <= {CMD_WORD[30:0], 1'b0};
                        addr_q   <= '0;
                        word_cnt <= '0;
                    end
                end
                CMD, DATA: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sck_q   <= !sck_q;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (sck_rise && (state == DATA)) begin
                        rx_sr <= {rx_sr[30:0], miso};
                    end
                    if (sck_fall) begin
                        // bit_cnt wraps 31 -> 0, ready for the next 32-bit stretch
                        bit_cnt <= bit_cnt + 1'b1;
                        if (state == CMD) begin
                            mosi_q <= bit_last ? 1'b0 : cmd_sr[31];
                            cmd_sr <= {cmd_sr[30:0], 1'b0};
                        end else if (bit_last) begin
                            // first byte received lands in the low byte of the word
                            wdata_q <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                        end
                    end
                end
                WRITE: begin
                    if (mem.gnt) begin
                        addr_q   <= addr_q + 1'b1;
                        word_cnt <= word_cnt + 1'b1;
                        div_cnt  <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_boot_sequencer.sv
// Self-checking bench for spi_boot_sequencer: three instances with SCK_DIV 2, 1 and 3,
// each driven by a behavioural mode-0 SPI flash and a memory-write monitor.
module tb_spi_boot_sequencer;

    localparam int ADDR_W = 14;
    localparam int WORDS  = 4;
    localparam int N_INST = 3;
    localparam int BUDGET = 4000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;

    logic              start  [N_INST];
    logic              skip   [N_INST];
    logic              gnt    [N_INST];
    logic              ss     [N_INST];
    logic              sck    [N_INST];
    logic              mosi   [N_INST];
    logic              busy   [N_INST];
    logic              done   [N_INST];
    logic              req    [N_INST];
    logic [ADDR_W-1:0] addr   [N_INST];
    logic [31:0]       wdata  [N_INST];
    logic [31:0]       cmd_seen [N_INST];
    logic [7:0]        byte_base [N_INST];

    logic [ADDR_W-1:0] obs_addr [N_INST][64];
    logic [31:0]       obs_data [N_INST][64];
    int                obs_n    [N_INST] = '{0, 0, 0};

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    always #5 clk = ~clk;

    // Flash model: byte n of the stream is base + n.
    function automatic logic flash_bit(input logic [7:0] base, input int b);
        logic [7:0] v;
        v = base + 8'(b / 8);
        return v[7 - (b % 8)];
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] base, input int k);
        logic [7:0] b0, b1, b2, b3;
        b0 = base + 8'(4 * k);
        b1 = base + 8'(4 * k + 1);
        b2 = base + 8'(4 * k + 2);
        b3 = base + 8'(4 * k + 3);
        return {b3, b2, b1, b0};
    endfunction

    for (genvar g = 0; g < N_INST; g++) begin : gi
        localparam int          DIV  = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        localparam logic [23:0] BASE = (g == 2) ? 24'h12A5C3 : 24'h000000;

        logic        so_bit;
        logic [31:0] cmd_rx = '0;
        int          rise_n = 0;

        spi_boot_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

        assign bus.gnt     = gnt[g];
        assign req[g]      = bus.req;
        assign addr[g]     = bus.addr;
        assign wdata[g]    = bus.wdata;
        assign cmd_seen[g] = cmd_rx;

        spi_boot_sequencer #(
            .ADDR_W     (ADDR_W),
            .BOOT_WORDS (WORDS),
            .SCK_DIV    (DIV),
            .FLASH_BASE (BASE)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .skip      (skip[g]),
            .ss        (ss[g]),
            .sck       (sck[g]),
            .mosi      (mosi[g]),
            .miso      (so_bit),
            .mem       (bus),
            .busy      (busy[g]),
            .boot_done (done[g])
        );

        // Flash receive side: count sck rises, capture the 32 command bits.
        always @(posedge sck[g] or posedge ss[g]) begin
            if (ss[g]) begin
                rise_n <= 0;
            end else begin
                if (rise_n < 32) cmd_rx <= {cmd_rx[30:0], mosi[g]};
                rise_n <= rise_n + 1;
            end
        end

        // Flash transmit side: mode 0, next data bit launched on sck fall.
        always @(negedge sck[g]) begin
            if (!ss[g] && rise_n >= 32) so_bit <= flash_bit(byte_base[g], rise_n - 32);
        end

        // Memory monitor: record every accepted write.
        always @(posedge clk) begin
            if (rst_n === 1'b1 && req[g] === 1'b1 && gnt[g] === 1'b1 && obs_n[g] < 64) begin
                obs_addr[g][obs_n[g]] <= addr[g];
                obs_data[g][obs_n[g]] <= wdata[g];
                obs_n[g]              <= obs_n[g] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N_INST; i++) begin
            start[i] = 1'b0;
            skip[i]  = 1'b0;
            gnt[i]   = 1'b1;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_image(input int g);
        wr_t e;
        for (int k = 0; k < WORDS; k++) begin
            e.addr = ADDR_W'(k);
            e.data = exp_word(byte_base[g], k);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int g);
        start[g] = 1'b1;
        tick();
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input string name);
        int c = 0;
        while (done[g] !== 1'b1 && c < BUDGET) begin
            tick();
            c++;
        end
        n_tests++;
        if (done[g] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: boot_done=%b required 1 within %0d cycles", name, done[g], BUDGET);
        end
    endtask

    // Pop every expected write and compare against the monitor's record, in order.
    task automatic drain_scoreboard(input int g, input int first, input string name);
        wr_t e;
        int  idx = first;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (idx >= obs_n[g]) begin
                n_fail++;
                $display("FAIL %s_write%0d: no write seen, required addr=%0d data=%08h", name, idx - first, e.addr, e.data);
            end else if (obs_addr[g][idx] !== e.addr || obs_data[g][idx] !== e.data) begin
                n_fail++;
                $display("FAIL %s_write%0d: got addr=%0d data=%08h required addr=%0d data=%08h",
                         name, idx - first, obs_addr[g][idx], obs_data[g][idx], e.addr, e.data);
            end
            idx++;
        end
        n_tests++;
        if (obs_n[g] - first != WORDS) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d required %0d", name, obs_n[g] - first, WORDS);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int g = 0; g < N_INST; g++) begin
            n_tests++;
            if ({ss[g], sck[g], mosi[g], req[g], busy[g], done[g]} !== 6'b100000) begin
                n_fail++;
                $display("FAIL reset_ctl%0d: ss,sck,mosi,req,busy,done got %b%b%b%b%b%b required 100000",
                         g, ss[g], sck[g], mosi[g], req[g], busy[g], done[g]);
            end
            n_tests++;
            if (addr[g] !== '0 || wdata[g] !== '0) begin
                n_fail++;
                $display("FAIL reset_bus%0d: addr=%0d wdata=%08h required 0/00000000", g, addr[g], wdata[g]);
            end
        end
        do_reset();
        for (int g = 0; g < N_INST; g++) begin
            n_tests++;
            if (ss[g] !== 1'b1 || busy[g] !== 1'b0 || done[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle%0d: ss=%b busy=%b done=%b required 1/0/0", g, ss[g], busy[g], done[g]);
            end
        end
    endtask

    task automatic test_boot();
        int first;
        do_reset();
        byte_base[0] = 8'h00;
        first = obs_n[0];
        push_image(0);
        pulse_start(0);
        n_tests++;
        if (ss[0] !== 1'b0 || busy[0] !== 1'b1 || sck[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_accept: ss=%b busy=%b sck=%b required 0/1/0", ss[0], busy[0], sck[0]);
        end
        wait_done(0, "boot");
        n_tests++;
        if (cmd_seen[0] !== 32'h03000000) begin
            n_fail++;
            $display("FAIL boot_cmd: got %08h required 03000000", cmd_seen[0]);
        end
        n_tests++;
        if (ss[0] !== 1'b1 || req[0] !== 1'b0 || busy[0] !== 1'b0 || sck[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_end_ctl: ss=%b req=%b busy=%b sck=%b required 1/0/0/0", ss[0], req[0], busy[0], sck[0]);
        end
        n_tests++;
        if (addr[0] !== ADDR_W'(WORDS)) begin
            n_fail++;
            $display("FAIL boot_end_addr: got %0d required %0d", addr[0], WORDS);
        end
        drain_scoreboard(0, first, "boot");
    endtask

    task automatic test_skip();
        int first;
        int bad = 0;
        do_reset();
        first = obs_n[0];
        start[0] = 1'b1;
        skip[0]  = 1'b1;
        n_tests++;
        if (done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_pre: boot_done=%b required 0", done[0]);
        end
        tick();
        start[0] = 1'b0;
        skip[0]  = 1'b0;
        n_tests++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_done: boot_done=%b busy=%b required 1/0", done[0], busy[0]);
        end
        for (int c = 0; c < 40; c++) begin
            if (ss[0] !== 1'b1 || req[0] !== 1'b0 || sck[0] !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0 || obs_n[0] != first) begin
            n_fail++;
            $display("FAIL skip_quiet: %0d active cycles, %0d writes, required 0/0", bad, obs_n[0] - first);
        end
    endtask

    task automatic test_stall();
        int          first;
        int          c = 0;
        logic [31:0] w1;
        do_reset();
        byte_base[0] = 8'h20;
        first = obs_n[0];
        w1 = exp_word(8'h20, 1);
        push_image(0);
        pulse_start(0);
        while (!(req[0] === 1'b1 && addr[0] === ADDR_W'(1)) && c < BUDGET) begin
            tick();
            c++;
        end
        gnt[0] = 1'b0;
        n_tests++;
        if (req[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_reach: req=%b addr=%0d required 1/1", req[0], addr[0]);
        end else begin
            for (int k = 0; k < 10; k++) begin
                tick();
                n_tests++;
                if (req[0] !== 1'b1 || addr[0] !== ADDR_W'(1) || wdata[0] !== w1 || sck[0] !== 1'b0 || ss[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_hold%0d: req=%b addr=%0d wdata=%08h sck=%b ss=%b required 1/1/%08h/0/0",
                             k, req[0], addr[0], wdata[0], sck[0], ss[0], w1);
                end
            end
            gnt[0] = 1'b1;
            tick();
            n_tests++;
            if (req[0] !== 1'b0 || addr[0] !== ADDR_W'(2)) begin
                n_fail++;
                $display("FAIL stall_release: req=%b addr=%0d required 0/2", req[0], addr[0]);
            end
        end
        gnt[0] = 1'b1;
        wait_done(0, "stall");
        drain_scoreboard(0, first, "stall");
    endtask

    task automatic test_reset_mid();
        int   first;
        int   c = 0;
        int   rises = 0;
        logic prev;
        do_reset();
        byte_base[0] = 8'h40;
        first = obs_n[0];
        pulse_start(0);
        while (obs_n[0] - first < 2 && c < BUDGET) begin
            tick();
            c++;
        end
        prev = sck[0];
        c = 0;
        while (rises < 18 && c < 400) begin
            tick();
            if (!prev && sck[0]) rises++;
            prev = sck[0];
            c++;
        end
        n_tests++;
        if (rises != 18) begin
            n_fail++;
            $display("FAIL abort_reach: saw %0d sck rises in word 2, required 18", rises);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ss[0] !== 1'b1 || sck[0] !== 1'b0 || req[0] !== 1'b0 || busy[0] !== 1'b0 || mosi[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: ss=%b sck=%b req=%b busy=%b mosi=%b required 1/0/0/0/0",
                     ss[0], sck[0], req[0], busy[0], mosi[0]);
        end
        n_tests++;
        if (addr[0] !== '0 || obs_n[0] - first != 2) begin
            n_fail++;
            $display("FAIL abort_state: addr=%0d writes=%0d required 0/2", addr[0], obs_n[0] - first);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        first = obs_n[0];
        push_image(0);
        pulse_start(0);
        wait_done(0, "restart");
        n_tests++;
        if (cmd_seen[0] !== 32'h03000000) begin
            n_fail++;
            $display("FAIL restart_cmd: got %08h required 03000000", cmd_seen[0]);
        end
        drain_scoreboard(0, first, "restart");
    endtask

    task automatic test_back_to_back();
        int first;
        int c = 0;
        int after;
        do_reset();
        byte_base[0] = 8'h60;
        first = obs_n[0];
        push_image(0);
        pulse_start(0);
        while (done[0] !== 1'b1 && c < BUDGET) begin
            start[0] = (c % 37 == 5) ? 1'b1 : 1'b0;
            tick();
            c++;
        end
        start[0] = 1'b0;
        n_tests++;
        if (done[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL retrig_done: boot_done=%b required 1", done[0]);
        end
        after = obs_n[0];
        pulse_start(0);
        repeat (60) tick();
        n_tests++;
        if (obs_n[0] != after || ss[0] !== 1'b1 || done[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL retrig_after_done: extra writes=%0d ss=%b done=%b required 0/1/1", obs_n[0] - after, ss[0], done[0]);
        end
        drain_scoreboard(0, first, "retrig");
    endtask

    task automatic test_sck_div();
        int first;
        int c;
        int hi;
        int lo;
        int div;
        logic [31:0] cmd_exp;
        for (int g = 1; g < N_INST; g++) begin
            do_reset();
            div = (g == 1) ? 1 : 3;
            cmd_exp = (g == 1) ? 32'h03000000 : 32'h0312A5C3;
            byte_base[g] = 8'h80 + 8'(16 * g);
            first = obs_n[g];
            push_image(g);
            pulse_start(g);
            c = 0;
            while (sck[g] !== 1'b1 && c < 50) begin
                tick();
                c++;
            end
            for (int b = 0; b < 3; b++) begin
                hi = 0;
                while (sck[g] === 1'b1 && hi < 20) begin
                    hi++;
                    tick();
                end
                lo = 0;
                while (sck[g] === 1'b0 && lo < 20) begin
                    lo++;
                    tick();
                end
                n_tests++;
                if (hi != div || lo != div) begin
                    n_fail++;
                    $display("FAIL div%0d_phase%0d: high=%0d low=%0d cycles required %0d/%0d", div, b, hi, lo, div, div);
                end
            end
            wait_done(g, "div");
            n_tests++;
            if (cmd_seen[g] !== cmd_exp) begin
                n_fail++;
                $display("FAIL div%0d_cmd: got %08h required %08h", div, cmd_seen[g], cmd_exp);
            end
            drain_scoreboard(g, first, (g == 1) ? "div1" : "div3");
        end
    endtask

    initial begin
        for (int i = 0; i < N_INST; i++) begin
            start[i]     = 1'b0;
            skip[i]      = 1'b0;
            gnt[i]       = 1'b1;
            byte_base[i] = 8'h00;
        end
        rst_n = 1'b0;
        test_reset();
        test_boot();
        test_skip();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_sck_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
